// File: rtl/parity_frame_checker.sv
// parity_frame_checker: per-word even/odd parity generation and checking on a
// valid/ready stream, with per-frame parity/error summaries and a saturating
// running mismatch counter.
//
// Handshake: a word transfers on any rising edge where in_valid && in_ready
// (input side) or out_valid && out_ready (output side). Once raised, valid and
// its data hold until the transfer. in_ready is combinational from the output
// register state, giving a single output stage with no skid buffer.
module parity_frame_checker #(
   parameter int WIDTH     = 9,
   parameter int FRAME_LEN = 8,
   parameter int ERR_W     = 8,
   localparam int FE_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             odd_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_parity,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_parity,
   output logic             out_err,
   output logic             frame_done,
   output logic             frame_parity,
   output logic [FE_W-1:0]  frame_errs,
   input  logic             clr_errs,
   output logic [ERR_W-1:0] total_errs,
   output logic             dbg_state
);

   localparam int WI_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   // IDLE: next accepted word is word 0 of a frame; RUN: inside a frame.
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [WI_W-1:0]   widx_q, widx_d;
   logic              mode_q;
   logic              facc_q;
   logic [FE_W-1:0]   ferr_q;
   logic              out_valid_q;
   logic [WIDTH-1:0]  out_data_q;
   logic              out_parity_q;
   logic              out_err_q;
   logic              frame_done_q;
   logic              frame_parity_q;
   logic [FE_W-1:0]   frame_errs_q;
   logic [ERR_W-1:0]  total_q, total_d;

   logic              accept;
   logic              first_word;
   logic              last_word;
   logic              word_x;
   logic              mode_cur;
   logic              gen_bit;
   logic              word_err;
   logic              facc_new;
   logic [FE_W-1:0]   ferr_new;

   assign in_ready   = !reset && (!out_valid_q || out_ready);
   assign accept     = in_valid && in_ready;
   assign first_word = (state_q == IDLE);
   assign last_word  = (widx_q == WI_W'(FRAME_LEN - 1));
   assign word_x     = ^in_data;
   // Mode is taken live on word 0 and held from the latch for the rest.
   assign mode_cur   = first_word ? odd_mode : mode_q;
   assign gen_bit    = word_x ^ mode_cur;
   assign word_err   = in_parity ^ gen_bit;
   // Accumulators restart on word 0 rather than folding in the previous frame.
   assign facc_new   = first_word ? word_x : (facc_q ^ word_x);
   assign ferr_new   = first_word ? FE_W'(word_err) : (ferr_q + FE_W'(word_err));

   // Frame position FSM: advances per accepted word, wraps on the last word.
   always_comb begin
      state_d = state_q;
      widx_d  = widx_q;
      if (accept) begin
         if (last_word) begin
            state_d = IDLE;
            widx_d  = '0;
         end else begin
            state_d = RUN;
            widx_d  = widx_q + WI_W'(1);
         end
      end
   end

   // Running mismatch count: saturating increment, clear wins but keeps a
   // mismatch accepted in the same cycle.
   always_comb begin
      total_d = total_q;
      if (clr_errs) begin
         total_d = (accept && word_err) ? ERR_W'(1) : '0;
      end else if (accept && word_err && (total_q != {ERR_W{1'b1}})) begin
         total_d = total_q + ERR_W'(1);
      end
   end

   // State, output register and frame accumulators; stalls hold everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         widx_q         <= '0;
         mode_q         <= 1'b0;
         facc_q         <= 1'b0;
         ferr_q         <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_parity_q   <= 1'b0;
         out_err_q      <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_parity_q <= 1'b0;
         frame_errs_q   <= '0;
         total_q        <= '0;
      end else begin
         state_q      <= state_d;
         widx_q       <= widx_d;
         total_q      <= total_d;
         frame_done_q <= accept && last_word;
         if (accept) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= in_data;
            out_parity_q <= gen_bit;
            out_err_q    <= word_err;
            mode_q       <= mode_cur;
            facc_q       <= facc_new;
            ferr_q       <= ferr_new;
            if (last_word) begin
               frame_parity_q <= facc_new ^ mode_cur;
               frame_errs_q   <= ferr_new;
            end
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_parity   = out_parity_q;
   assign out_err      = out_err_q;
   assign frame_done   = frame_done_q;
   assign frame_parity = frame_parity_q;
   assign frame_errs   = frame_errs_q;
   assign total_errs   = total_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker with WIDTH=9, FRAME_LEN=4, ERR_W=2.
// Driver pushes hand-computed word/frame results; a negedge monitor pops them.
module tb_parity_frame_checker;

   localparam int WIDTH     = 9;
   localparam int FRAME_LEN = 4;
   localparam int ERR_W     = 2;
   localparam int FE_W      = $clog2(FRAME_LEN + 1);

   logic             clk;
   logic             reset;
   logic             odd_mode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_parity;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_parity;
   logic             out_err;
   logic             frame_done;
   logic             frame_parity;
   logic [FE_W-1:0]  frame_errs;
   logic             clr_errs;
   logic [ERR_W-1:0] total_errs;
   logic             dbg_state;

   parity_frame_checker #(
      .WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .ERR_W(ERR_W)
   ) dut (
      .clk(clk), .reset(reset), .odd_mode(odd_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_parity(in_parity), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_parity(out_parity), .out_err(out_err),
      .frame_done(frame_done), .frame_parity(frame_parity),
      .frame_errs(frame_errs), .clr_errs(clr_errs),
      .total_errs(total_errs), .dbg_state(dbg_state)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   // Scoreboard state
   int checks = 0;
   int errors = 0;
   logic [WIDTH+1:0] exp_q[$];   // {data, gen parity, err}
   logic [FE_W:0]    frame_q[$]; // {frame_parity, frame_errs}
   logic [WIDTH+1:0] mon_e;
   logic [FE_W:0]    mon_f;
   logic             fd_prev = 1'b0;
   int               w;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Monitor: compares every output handshake and every frame_done pulse
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (frame_done === 1'b1) begin
            check("frame_done_pulse_len", fd_prev, 0);
            check("frame_done_with_valid", out_valid, 1);
            check("frame_expected", frame_q.size() != 0, 1);
            if (frame_q.size() != 0) begin
               mon_f = frame_q.pop_front();
               check("frame_parity", frame_parity, mon_f[FE_W]);
               check("frame_errs", frame_errs, mon_f[FE_W-1:0]);
            end
         end
         fd_prev = (frame_done === 1'b1);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            check("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("out_data", out_data, mon_e[WIDTH+1:2]);
               check("out_parity", out_parity, mon_e[1]);
               check("out_err", out_err, mon_e[0]);
            end
         end
      end else begin
         fd_prev = 1'b0;
      end
   end

   // Driver tasks: all start and end at posedge+1
   task automatic send_word(input logic [WIDTH-1:0] d, input logic p, input logic g,
                            output int waits);
      in_valid  = 1'b1;
      in_data   = d;
      in_parity = p;
      waits     = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && waits < 20) begin
         waits++;
         @(negedge clk);
      end
      if (in_ready !== 1'b1) begin
         check("accept_timeout", waits, 0);
         in_valid = 1'b0;
      end else begin
         exp_q.push_back({d, g, p ^ g});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] d, input logic p, input logic g);
      int wt;
      send_word(d, p, g, wt);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_frame(input logic fp, input logic [FE_W-1:0] fe);
      frame_q.push_back({fp, fe});
   endtask

   task automatic check_total(input logic [ERR_W-1:0] exp);
      check("total_errs", total_errs, exp);
   endtask

   initial begin
      // Reset with garbage inputs
      reset = 1'b1; in_valid = 1'b1; in_data = 9'h155; in_parity = 1'b1;
      odd_mode = 1'b1; clr_errs = 1'b1; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_parity", out_parity, 0);
      check("rst_out_err", out_err, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_parity", frame_parity, 0);
      check("rst_frame_errs", frame_errs, 0);
      check("rst_total_errs", total_errs, 0);
      check("rst_in_ready", in_ready, 0);
      reset = 1'b0; in_valid = 1'b0; clr_errs = 1'b0; odd_mode = 1'b0;
      @(negedge clk);
      check("in_ready_after_release", in_ready, 1);
      @(posedge clk);
      #1;

      // Frame A (even): parity of 1FF, then back-pressure on 0A5
      send(9'h1FF, 1'b1, 1'b1);
      send(9'h000, 1'b0, 1'b0);
      send(9'h0A5, 1'b0, 1'b0);
      out_ready = 1'b0; in_valid = 1'b1; in_data = 9'h003; in_parity = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_out_data", out_data, 9'h0A5);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      expect_frame(1'b1, 3'd0);
      send_word(9'h003, 1'b0, 1'b0, w);
      check("release_wait", w, 0);
      odd_mode = 1'b1;

      // Frame B (odd): same 1FF word now mismatches
      send_word(9'h1FF, 1'b1, 1'b0, w);
      check("back_to_back_wait", w, 0);
      check_total(2'd1);
      send(9'h001, 1'b0, 1'b0);
      send(9'h000, 1'b1, 1'b1);
      expect_frame(1'b1, 3'd1);
      send(9'h003, 1'b1, 1'b1);

      // Frame C (even), odd_mode raised after word 1 must not apply yet
      odd_mode = 1'b0;
      send(9'h001, 1'b1, 1'b1);
      send(9'h003, 1'b0, 1'b0);
      odd_mode = 1'b1;
      send(9'h000, 1'b1, 1'b0);
      check_total(2'd2);
      expect_frame(1'b0, 3'd1);
      send(9'h100, 1'b1, 1'b1);

      // Frame D (odd): consecutive mismatches saturate the counter
      send(9'h000, 1'b0, 1'b1);
      check_total(2'd3);
      send(9'h000, 1'b0, 1'b1);
      send(9'h000, 1'b0, 1'b1);
      expect_frame(1'b1, 3'd4);
      send(9'h000, 1'b0, 1'b1);
      check_total(2'd3);

      // Frame E (odd, partial): clear with and without a mismatch
      send(9'h000, 1'b0, 1'b1);
      check_total(2'd3);
      clr_errs = 1'b1;
      send(9'h000, 1'b0, 1'b1);
      clr_errs = 1'b0;
      check_total(2'd1);
      in_valid = 1'b0;
      clr_errs = 1'b1;
      @(posedge clk);
      #1;
      clr_errs = 1'b0;
      check_total(2'd0);
      send(9'h1FF, 1'b0, 1'b0);
      idle(2);

      // Reset mid-frame: partial frame E discarded
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      odd_mode = 1'b0;
      idle(1);

      // Frame F (even) from a fresh word index
      send(9'h1FF, 1'b1, 1'b1);
      send(9'h001, 1'b0, 1'b1);
      send(9'h0A5, 1'b0, 1'b0);
      expect_frame(1'b0, 3'd1);
      send(9'h000, 1'b0, 1'b0);
      check_total(2'd1);
      idle(4);

      check("word_queue_drained", exp_q.size(), 0);
      check("frame_queue_drained", frame_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Parametrised, clocked successor to the 9-bit even/odd parity generator. Accepts a stream of WIDTH-bit words over a valid/ready handshake, generates each word's even- or odd-parity bit, checks it against a received parity bit, and registers the result. It also accumulates per-frame parity and error counts over fixed-length frames of FRAME_LEN words. It sits between a word source (e.g. a deserialiser) and a consumer that needs parity-protected words plus frame-level integrity status.

## Interface
- WIDTH, 9: data word width in bits; must be ≥ 1.
- FRAME_LEN, 8: words per frame; must be ≥ 1.
- ERR_W, 8: width of the running error counter; must be ≥ 1.

- clk  input  1  rising-edge clock; only clock.
- reset  input  1  synchronous, active-high reset.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled per frame.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  data word.
- in_parity  input  1  received parity bit to check.
- out_valid  output  1  registered result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  registered copy of accepted word.
- out_parity  output  1  generated parity bit for out_data.
- out_err  output  1  in_parity mismatched the generated bit.
- frame_done  output  1  one-cycle pulse; frame summary valid.
- frame_parity  output  1  parity over all WIDTH×FRAME_LEN bits of the frame.
- frame_errs  output  clog2(FRAME_LEN+1)  count of mismatched words in the frame.
- clr_errs  input  1  clears total_errs.
- total_errs  output  ERR_W  saturating count of all mismatches since reset or clear.

## Operation
- Accept: in_valid && in_ready. in_ready = !reset && (!out_valid || out_ready), which is combinational and gives a single output register with no skid.
- Word parity: x = XOR of in_data bits. gen = x when in even mode and ~x when in odd mode, so the total number of ones in data plus gen is even or odd respectively. out_err = (in_parity != gen).
- Mode latch: odd_mode is captured on the accept of word 0 of each frame and held through word FRAME_LEN-1. Changes mid-frame take effect at the next frame.
- Word counter: widx counts 0..FRAME_LEN-1 and advances on each accept. It wraps to 0 after FRAME_LEN-1. When FRAME_LEN = 1, every word is its own frame.
- Frame accumulators:
  - facc (XOR of x values) is seeded on word 0, not OR-ed with stale data.
  - ferr (error count) is seeded the same way.
  - On the last word, frame_parity = final facc XOR latched_mode, and frame_errs = final ferr.
- States:
  - IDLE: after reset, widx = 0.
  - RUN: 0 < widx < FRAME_LEN. Entered on accept of word 0 when FRAME_LEN > 1; returns to IDLE on accept of the last word.
  - Stalls (out_valid && !out_ready) hold every register in either state.
- total_errs:
  - Increments by 1 on each accepted mismatch.
  - Saturates at 2^ERR_W-1.
  - If clr_errs and an accepted mismatch occur in the same cycle, the result is 1. clr_errs alone gives 0.
- Reset mid-frame: the partial frame is discarded, and no frame_done is issued for it.

## Timing
- Latency: a word accepted at edge N drives out_valid, out_data, out_parity and out_err from edge N through the edge on which out_valid && out_ready is true.
- out_valid falls after the handshake unless a new word is accepted in that same cycle (back-to-back throughput is 1 word/cycle).
- frame_done is high for exactly one cycle: the first cycle out_valid presents the frame's last word. frame_parity and frame_errs are valid in that cycle and hold until the next frame_done.
- Output values in the cycle after reset is asserted:
  - 0: out_valid, out_data, out_parity, out_err, frame_done, frame_parity, frame_errs, total_errs.
  - in_ready = 0 while reset is high and 1 in the first cycle after it is released.
- Outputs are stable while stalled; out_data must not change while out_valid && !out_ready.

## Test plan
- Reset: hold reset for 2 cycles with garbage inputs, then release → all outputs 0 during reset, and in_ready = 1 on the first cycle after release.
- Word parity, WIDTH=9:
  - Even mode, 9'h1FF with in_parity=1 → one cycle later out_parity=1, out_err=0.
  - Odd mode (new frame), same word and in_parity → out_parity=0, out_err=1, total_errs=1.
- Back-pressure: accept 9'h0A5, then hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and out_data=9'h0A5 stable for all 3 cycles. Releasing out_ready yields one handshake per cycle.
- Frame, FRAME_LEN=4, even mode: words 9'h001, 9'h003, 9'h000, 9'h100 with in_parity 1, 0, 1, 1 (third is wrong) → frame_done a single pulse alongside the 4th out_valid, frame_parity=0, frame_errs=1.
- Mode latch: set odd_mode=1 after word 1 of an even frame → remaining words of that frame use even parity, and the next frame's word 0 uses odd parity.
- Saturation, ERR_W=2: 5 consecutive mismatches → total_errs=3. Then assert clr_errs in the same cycle as a mismatch accept → total_errs=1. A later reset mid-frame gives no frame_done, and a subsequent full frame reports from a fresh widx=0.
